// File: rtl/hdmi_audio_pkg.sv
// Shared types and constants for the HDMI audio sample path.
package hdmi_audio_pkg;

  localparam int IEC60958_FRAME_LEN     = 192;
  localparam int MAX_SAMPLES_PER_PACKET = 4;

  typedef logic [23:0] audio_word_t;
  typedef audio_word_t stereo_pair_t [1:0];

endpackage

// File: rtl/audio_sample_fifo.sv
// Stereo-pair FIFO with a four-entry peek window so a whole packet pops in one cycle.
module audio_sample_fifo
  import hdmi_audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         push,
  input  stereo_pair_t push_pair,
  input  logic         drop_oldest,
  input  logic [2:0]   pop_n,
  output logic [CW-1:0] count,
  output stereo_pair_t peek [MAX_SAMPLES_PER_PACKET]
);

  stereo_pair_t  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr] <= push_pair;
  end

  // drop_oldest only happens when full with no pop, so it just slides the read pointer
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n) + AW'(drop_oldest);
      count  <= count - CW'(pop_n) + CW'(push) - CW'(drop_oldest);
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_SAMPLES_PER_PACKET; i++) begin
      peek[i] = mem[rd_ptr + AW'(i)];
    end
  end

endmodule

// File: rtl/audio_sample_collector.sv
// Buffers stereo PCM pairs and releases up to four per audio sample packet request.
// Build option AUDIO_SAMPLE_COLLECTOR_DROP_OLDEST_EN: on overflow discard the oldest pair instead of the newest.
module audio_sample_collector
  import hdmi_audio_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       audio_sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0] audio_sample_left,
  input  logic [AUDIO_BIT_WIDTH-1:0] audio_sample_right,
  input  logic                       packet_request,
  output logic                       packet_ready,
  output logic                       packet_valid,
  output logic [7:0]                 frame_counter,
  output logic [3:0][1:0][23:0]      audio_sample_word,
  output logic [3:0]                 audio_sample_word_present,
  output logic [3:0][1:0]            valid_bit,
  output logic [3:0][1:0]            user_data_bit,
  output logic                       overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] count_after_pop;
  logic [2:0]    n_avail;
  logic [2:0]    n_pop;
  logic          full_after_pop;
  logic          push;
  logic          drop_oldest;
  logic          discard;
  logic [3:0]    pop_mask;
  logic [7:0]    fc;
  logic [8:0]    fc_sum;
  logic [7:0]    fc_next;
  stereo_pair_t  push_pair;
  stereo_pair_t  peek [MAX_SAMPLES_PER_PACKET];

  always_comb begin
    push_pair[0] = audio_word_t'(audio_sample_left) << (24 - AUDIO_BIT_WIDTH);
    push_pair[1] = audio_word_t'(audio_sample_right) << (24 - AUDIO_BIT_WIDTH);
  end

  always_comb begin
    n_avail         = (count >= CW'(MAX_SAMPLES_PER_PACKET)) ? 3'd4 : count[2:0];
    n_pop           = packet_request ? n_avail : 3'd0;
    count_after_pop = count - CW'(n_pop);
    full_after_pop  = (count_after_pop == CW'(FIFO_DEPTH));
    pop_mask        = 4'((5'd1 << n_avail) - 5'd1);
  end

`ifdef AUDIO_SAMPLE_COLLECTOR_DROP_OLDEST_EN
  always_comb begin
    push        = audio_sample_valid;
    drop_oldest = audio_sample_valid && full_after_pop;
    discard     = drop_oldest;
  end
`else
  always_comb begin
    push        = audio_sample_valid && !full_after_pop;
    drop_oldest = 1'b0;
    discard     = audio_sample_valid && full_after_pop;
  end
`endif

  // 9-bit sum keeps fc+4 from wrapping before the frame-length compare
  always_comb begin
    fc_sum  = {1'b0, fc} + 9'(n_pop);
    fc_next = (fc_sum >= 9'(IEC60958_FRAME_LEN)) ? 8'(fc_sum - 9'(IEC60958_FRAME_LEN))
                                                 : fc_sum[7:0];
  end

  audio_sample_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .push        (push),
    .push_pair   (push_pair),
    .drop_oldest (drop_oldest),
    .pop_n       (n_pop),
    .count       (count),
    .peek        (peek)
  );

  assign packet_ready  = (count != '0);
  assign valid_bit     = '0;
  assign user_data_bit = '0;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      fc                        <= '0;
      frame_counter             <= '0;
      packet_valid              <= 1'b0;
      overflow                  <= 1'b0;
      audio_sample_word         <= '0;
      audio_sample_word_present <= '0;
    end else begin
      fc           <= fc_next;
      packet_valid <= packet_request;
      if (discard) overflow <= 1'b1;
      if (packet_request) begin
        frame_counter             <= fc;
        audio_sample_word_present <= pop_mask;
        for (int i = 0; i < MAX_SAMPLES_PER_PACKET; i++) begin
          audio_sample_word[i][0] <= pop_mask[i] ? peek[i][0] : 24'h0;
          audio_sample_word[i][1] <= pop_mask[i] ? peek[i][1] : 24'h0;
        end
      end
    end
  end

endmodule
